// File: rtl/segled_pkg.sv
// Shared types for the seven-segment scan driver: glyph codes, segment table, FSM states.
package segled_pkg;

  typedef logic [4:0] glyph_t;

  localparam glyph_t GL_BLANK = 5'd16;
  localparam glyph_t GL_MINUS = 5'd17;
  localparam glyph_t GL_ERR   = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Active-high {g,f,e,d,c,b,a}; index is the glyph code.
  localparam logic [6:0] GLYPH_SEG [0:18] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
    7'h00, 7'h40, 7'h79
  };

  function automatic logic [6:0] glyph_to_seg(input glyph_t g);
    logic [6:0] s;
    s = 7'h00;
    if (g <= GL_ERR) s = GLYPH_SEG[g];
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one magnitude bit per clock, MSB first.
// done is high during the final shift cycle; bcd/ovf are final from the next edge.
module bin2bcd_seq #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;
  logic [BCD_W-1:0]  w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (start) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_ovf <= 1'b0;
      r_cnt <= CNT_W'(DATA_W);
    end else if (busy) begin
      // A carry out of the top digit means the value needs more digits than we have.
      r_bcd <= {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
      r_bin <= r_bin << 1;
      r_ovf <= r_ovf | w_adj[BCD_W-1];
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign busy = (r_cnt != '0);
  assign done = (r_cnt == CNT_W'(1));
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

// File: rtl/segled_scan_n.sv
// Multiplexed seven-segment driver: captures a value, converts to glyphs (BCD or hex),
// and scans the committed frame onto shared segment lines.
//   state     | meaning
//   ST_IDLE   | waiting for load; frame displayed unchanged
//   ST_CONV   | double-dabble running (decimal only)
//   ST_COMMIT | frame and ovf registered atomically
module segled_scan_n
  import segled_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DATA_W         = 32,
  parameter int SCAN_DIV       = 16384,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] input_data,
  input  logic              load,
  input  logic              mode_hex,
  input  logic              signed_en,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic              ovf,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] dig_sel
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int HEX_N  = (DATA_W < BCD_W) ? DATA_W : BCD_W;
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t r_state, w_next;
  logic   w_capture, w_commit, w_start;

  logic              r_busy, r_ovf;
  logic              r_hex, r_neg, r_blank;
  logic [DATA_W-1:0] r_data;
  glyph_t            r_frame [DIGITS];

  logic              w_neg;
  logic [DATA_W-1:0] w_mag;
  logic              w_eng_busy, w_eng_done, w_eng_ovf;
  logic [BCD_W-1:0]  w_eng_bcd;
  logic [BCD_W-1:0]  w_hex_flat;
  logic              w_hex_ovf, w_ovf;
  logic [3:0]        w_dig [DIGITS];
  int                w_hi, w_mpos;
  glyph_t            w_frame [DIGITS];

  logic [SCAN_W-1:0] r_scan_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_seg;
  logic [DIGITS-1:0] r_dig;
  logic [7:0]        w_seg_act;
  logic [DIGITS-1:0] w_dig_act;

  assign w_neg   = !mode_hex && signed_en && input_data[DATA_W-1];
  assign w_mag   = w_neg ? -input_data : input_data;
  assign w_start = w_capture && !mode_hex;

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (w_start),
    .bin       (w_mag),
    .busy      (w_eng_busy),
    .done      (w_eng_done),
    .bcd       (w_eng_bcd),
    .ovf       (w_eng_ovf)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_capture = 1'b1;
          w_next    = mode_hex ? ST_COMMIT : ST_CONV;
        end
      end
      ST_CONV: begin
        if (w_eng_done || !w_eng_busy) w_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hex   <= 1'b0;
      r_neg   <= 1'b0;
      r_blank <= 1'b0;
      r_data  <= '0;
    end else if (w_capture) begin
      r_hex   <= mode_hex;
      r_neg   <= w_neg;
      r_blank <= blank_lz;
      r_data  <= input_data;
    end
  end

  always_comb begin
    w_hex_flat = '0;
    w_hex_flat[HEX_N-1:0] = r_data[HEX_N-1:0];
    w_hex_ovf = 1'b0;
    for (int k = HEX_N; k < DATA_W; k++) w_hex_ovf = w_hex_ovf | r_data[k];
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      w_dig[i] = r_hex ? w_hex_flat[4*i +: 4] : w_eng_bcd[4*i +: 4];
    end
  end

  // A negative value gives up its top digit to the sign.
  assign w_ovf = r_hex ? w_hex_ovf
                       : (w_eng_ovf || (r_neg && (w_dig[DIGITS-1] != 4'd0)));

  always_comb begin
    w_hi = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_dig[i] != 4'd0) w_hi = i;
    end
    w_mpos  = r_blank ? (w_hi + 1) : (DIGITS - 1);
    w_frame = '{default: GL_BLANK};
    for (int i = 0; i < DIGITS; i++) begin
      if (w_ovf)                      w_frame[i] = GL_ERR;
      else if (r_neg && i == w_mpos)  w_frame[i] = GL_MINUS;
      else if (r_blank && i > w_hi)   w_frame[i] = GL_BLANK;
      else                            w_frame[i] = glyph_t'({1'b0, w_dig[i]});
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame <= '{default: GL_BLANK};
      r_ovf   <= 1'b0;
    end else if (w_commit) begin
      r_frame <= w_frame;
      r_ovf   <= w_ovf;
    end
  end

  assign w_seg_act = {dp_mask[r_idx], glyph_to_seg(r_frame[r_idx])};
  assign w_dig_act = DIGITS'(1) << r_idx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_seg      <= {8{SEG_ACTIVE_LOW}};
      r_dig      <= {DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
      r_seg <= w_seg_act ^ {8{SEG_ACTIVE_LOW}};
      r_dig <= w_dig_act ^ {DIGITS{DIG_ACTIVE_LOW}};
    end
  end

  assign busy    = r_busy;
  assign ovf     = r_ovf;
  assign seg     = r_seg;
  assign dig_sel = r_dig;

endmodule

// File: tb/tb_segled_scan_n.sv
// Directed bench for segled_scan_n: table of load vectors with hand-computed glyphs,
// plus reset, ignored-load and reset-abort sequences.
module tb_segled_scan_n;

  localparam int DIGITS   = 4;
  localparam int DATA_W   = 32;
  localparam int SCAN_DIV = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [DATA_W-1:0] input_data = '0;
  logic              load = 1'b0, mode_hex = 1'b0, signed_en = 1'b0, blank_lz = 1'b0;
  logic [DIGITS-1:0] dp_mask = '0;
  logic              busy, ovf;
  logic [7:0]        seg;
  logic [DIGITS-1:0] dig_sel;

  segled_scan_n #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .input_data(input_data), .load(load),
    .mode_hex(mode_hex), .signed_en(signed_en), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .busy(busy), .ovf(ovf), .seg(seg), .dig_sel(dig_sel)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] data;
    logic        hex, sgn, blz, ovf;
    logic [31:0] segs;   // active-high glyphs, digit 3 in the top byte
    int          bcyc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void add(input logic [31:0] d, input logic h, s, b, o,
                              input logic [31:0] sg, input int bc);
    vec_t v;
    v.data = d; v.hex = h; v.sgn = s; v.blz = b; v.ovf = o; v.segs = sg; v.bcyc = bc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic h, s, b, output int bcyc);
    @(negedge sys_clk);
    input_data = d; mode_hex = h; signed_en = s; blank_lz = b; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    bcyc = 0;
    while (busy && bcyc < 100) begin
      bcyc++;
      @(negedge sys_clk);
    end
  endtask

  task automatic read_frame(output logic [31:0] segs);
    segs = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      logic [3:0] want;
      int t;
      want = ~(4'b0001 << i);
      t = 0;
      while (dig_sel !== want && t < 64) begin
        @(negedge sys_clk);
        t++;
      end
      if (t >= 64) begin
        n_checks++;
        n_errors++;
        $display("FAIL scan_timeout digit %0d: got dig_sel %h", i, dig_sel);
      end
      segs[8*i +: 8] = ~seg;
    end
  endtask

  initial begin
    logic [31:0] fr;
    logic [3:0]  exp_dig [5];
    int          bc;

    add(32'd1234,     0, 0, 1, 0, 32'h065B4F66, 33);
    add(32'hFFFFFFD6, 0, 1, 1, 0, 32'h0040665B, 33);
    add(32'hFFFFFFD6, 0, 1, 0, 0, 32'h403F665B, 33);
    add(32'd9999,     0, 0, 1, 0, 32'h6F6F6F6F, 33);
    add(32'd0,        0, 0, 1, 0, 32'h0000003F, 33);
    add(32'd0,        0, 0, 0, 0, 32'h3F3F3F3F, 33);
    add(32'hFFFFFFFF, 0, 1, 1, 0, 32'h00004006, 33);
    add(32'd5,        0, 1, 1, 0, 32'h0000006D, 33);
    add(32'd1005,     0, 0, 1, 0, 32'h063F3F6D, 33);
    add(32'hFFFFFFF9, 0, 1, 0, 0, 32'h403F3F07, 33);
    add(32'hFFFFFC19, 0, 1, 1, 0, 32'h406F6F6F, 33);
    add(32'h000000AB, 1, 0, 0, 0, 32'h3F3F777C, 1);
    add(32'h000000AB, 1, 0, 1, 0, 32'h0000777C, 1);
    add(32'h0000FFFF, 1, 1, 1, 0, 32'h71717171, 1);
    add(32'h00010000, 1, 0, 1, 1, 32'h79797979, 1);
    add(32'h80000000, 0, 1, 1, 1, 32'h79797979, 33);
    add(32'hFFFFFC18, 0, 1, 1, 1, 32'h79797979, 33);
    add(32'd10000,    0, 0, 1, 1, 32'h79797979, 33);

    // Reset state
    dp_mask = 4'b0001;
    repeat (3) @(negedge sys_clk);
    check("rst_seg", {24'h0, seg}, 32'hFF);
    check("rst_dig", {28'h0, dig_sel}, 32'hF);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ovf", {31'h0, ovf}, 32'h0);

    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("first_seg_dp", {24'h0, seg}, 32'h7F);
    exp_dig = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    for (int k = 0; k < 5; k++) begin
      check($sformatf("scan_dig%0d", k), {28'h0, dig_sel}, {28'h0, exp_dig[k]});
      repeat (SCAN_DIV) @(negedge sys_clk);
    end
    dp_mask = '0;

    foreach (vecs[v]) begin
      do_load(vecs[v].data, vecs[v].hex, vecs[v].sgn, vecs[v].blz, bc);
      check($sformatf("v%0d_busy_cycles", v), bc, vecs[v].bcyc);
      check($sformatf("v%0d_ovf", v), {31'h0, ovf}, {31'h0, vecs[v].ovf});
      @(negedge sys_clk);
      read_frame(fr);
      check($sformatf("v%0d_frame", v), fr, vecs[v].segs);
    end

    // Load during conversion is ignored; old frame and ovf hold until commit.
    @(negedge sys_clk);
    input_data = 32'd1234; mode_hex = 0; signed_en = 0; blank_lz = 1; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (bc == 10) begin input_data = 32'd9999; load = 1'b1; end
      if (bc == 11) load = 1'b0;
      if (bc == 20) check("ign_ovf_hold", {31'h0, ovf}, 32'h1);
      @(negedge sys_clk);
    end
    check("ign_busy_cycles", bc, 33);
    check("ign_ovf", {31'h0, ovf}, 32'h0);
    @(negedge sys_clk);
    read_frame(fr);
    check("ign_frame", fr, 32'h065B4F66);

    // Reset mid-conversion aborts and blanks the display.
    @(negedge sys_clk);
    input_data = 32'd10000; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_seg", {24'h0, seg}, 32'hFF);
    check("abort_dig", {28'h0, dig_sel}, 32'hF);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    read_frame(fr);
    check("abort_frame_blank", fr, 32'h00000000);
    check("abort_ovf", {31'h0, ovf}, 32'h0);
    do_load(32'd1234, 0, 0, 1, bc);
    check("post_abort_busy", bc, 33);
    @(negedge sys_clk);
    read_frame(fr);
    check("post_abort_frame", fr, 32'h065B4F66);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/segled_scan_n.md
# segled_scan_n

Parametrised multiplexed seven-segment display driver for the MIPS board I/O path: captures a DATA_W-bit value on a load strobe and converts it to DIGITS display glyphs. Decimal conversion uses a sequential double-dabble engine; hex mode uses a direct nibble mapping. Options cover signed display, leading-zero blanking, per-digit decimal points and overflow indication. A free-running scan engine time-multiplexes the glyphs onto shared segment lines.

## Interface
- DIGITS, 4: number of display digits, 1..8. Digit 0 is least significant (rightmost).
- DATA_W, 32: input value width, 4..32.
- SCAN_DIV, 16384: sys_clk cycles each digit stays lit, ≥2.
- SEG_ACTIVE_LOW, 1: segment output polarity.
- DIG_ACTIVE_LOW, 1: digit-select output polarity.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset. Asynchronous, active-low.
- input_data  in  DATA_W  value to display.
- load  in  1  capture request, sampled each rising edge.
- mode_hex  in  1  1 = hex, 0 = decimal. Captured with load.
- signed_en  in  1  decimal only: input_data is two's complement. Captured with load.
- blank_lz  in  1  blank leading zeros. Captured with load.
- dp_mask  in  DIGITS  decimal point per digit. Live, not captured.
- busy  out  1  conversion in progress.
- ovf  out  1  last converted value did not fit.
- seg  out  8  {h,g,f,e,d,c,b,a}. h is the decimal point.
- dig_sel  out  DIGITS  one-hot digit enable.

## Operation
- FSM states: IDLE, CONV, COMMIT.
  - IDLE + load: capture operands, go to CONV (decimal) or COMMIT (hex).
  - CONV: run DATA_W shift cycles, then go to COMMIT.
  - COMMIT: write the frame register and ovf, return to IDLE.
- load outside IDLE is ignored. Requests are not queued.
- Negative input (decimal, signed_en=1, MSB=1): magnitude = two's-complement negation, held as an unsigned DATA_W value. The most negative value is valid.
- Decimal conversion: DIGITS×4-bit BCD register.
  - Each CONV cycle: add 3 to every digit ≥5, then shift left one bit, taking in the next magnitude bit MSB-first.
  - Any 1 shifted out of the top digit sets a sticky overflow flag.
- Digits available to the number: DIGITS, or DIGITS−1 when negative (one digit reserved for the sign).
  - Overflow = sticky flag set, or a negative value's top BCD digit is nonzero.
- Hex conversion: digit i = nibble i. Overflow = any nonzero bit above bit 4·DIGITS−1. signed_en is ignored.
- Frame build (COMMIT):
  - ovf=1: every digit shows E.
  - ovf=0, blank_lz=1: digits above the highest nonzero digit are blank. Digit 0 is always shown.
  - Minus sign goes in the digit directly left of the leftmost shown digit. With blank_lz=0 it goes in digit DIGITS−1.
- Glyphs, active-high {h..a} with h=0:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, b=7C, C=39, d=5E, E=79, F=71.
  - minus=40, blank=00.
- Scan:
  - Counter runs 0..SCAN_DIV−1; on wrap, the digit index steps (DIGITS−1 wraps to 0).
  - seg = glyph of frame[index], with h = dp_mask[index], then polarity applied.
  - dig_sel = one-hot(index), then polarity applied.

## Timing
- Reset (async assert):
  - State IDLE, busy=0, ovf=0, frame all blank, scan counter and index 0.
  - seg and dig_sel at their inactive levels: all ones when active-low.
- First rising edge after reset release: dig_sel enables digit 0. seg shows blank plus dp_mask[0].
- busy is registered. It rises on the edge that samples load in IDLE.
- Decimal latency: COMMIT entered DATA_W edges after capture. Frame, ovf and busy=0 take effect on the following edge, i.e. DATA_W+1 edges after capture.
- Hex latency: frame update 1 edge after capture.
- The old frame stays displayed until COMMIT. The update is atomic with no torn frame.
- seg and dig_sel are registered, one cycle after the index/frame change, and switch on the same edge.
- Reset mid-conversion: aborts immediately. Display returns to blank.

## Structure
- Shared package segled_pkg:
  - Glyph code type (5-bit: 0–15 hex digits, BLANK, MINUS, ERR).
  - Glyph-to-segment constant table.
  - FSM state enum.
- Sub-module bin2bcd_seq(DATA_W, DIGITS):
  - Ports: start, bin, busy, done, bcd, ovf.
  - Serial double-dabble engine.
- Top level: capture/sign logic, frame build, scan engine.

## Test plan
- Reset, with DIGITS=4, DATA_W=32, SCAN_DIV=4, active-low:
  - During reset: seg=FF, dig_sel=F.
  - After reset: dig_sel cycles E,D,B,7 every 4 clocks.
- Load 1234, decimal, blank_lz=1:
  - busy high for 33 cycles.
  - Frame becomes 1,2,3,4 (seg active-low F9,A4,B0,99 on digits 3..0). ovf=0.
- Load −42, signed_en=1, blank_lz=1:
  - Digits 3..0 = blank, minus, 4, 2.
  - With blank_lz=0: minus, 0, 4, 2.
- Overflow cases:
  - Load 10000: ovf=1, all digits E.
  - Load −1000 signed: ovf=1.
  - Load 9999: ovf=0.
- Load 0x000000AB, mode_hex=1:
  - blank_lz=0: frame 0,0,A,b after 1 edge.
  - blank_lz=1: blank, blank, A, b.
  - Load 0x10000: ovf=1.
- load pulsed mid-conversion: ignored, first result shown.
- Reset asserted mid-conversion: busy=0, frame blank, the next load converts normally.
